ps2_scan_rx: RTL

//  PS/2 device-to-host receiver feeding the lane decoder, which consumes key_byte/key_state.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_scan_rx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM encoding, prefix codes and the lane scan codes
// that the downstream lane decoder also matches on.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] PS2_LANE0 = 8'h1C;
    localparam logic [7:0] PS2_LANE1 = 8'h1B;
    localparam logic [7:0] PS2_LANE2 = 8'h42;
    localparam logic [7:0] PS2_LANE3 = 8'h4B;

    function automatic logic ps2_is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus level deglitcher for one PS/2 line: the output only follows
// the synchronised input once it has held a new level for FILTER_LEN consecutive cycles.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // Lines idle high, so reset to 1 to avoid a fake falling edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            dout <= 1'b1;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 != dout) begin
                if (cnt == CW'(FILTER_LEN - 1)) begin
                    dout <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host scan code receiver; folds E0/F0 prefixes into one key event.
// Define PS2_PARITY_CHK_EN to drop frames with bad odd parity.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_clk,
    input  logic       key_data,
    output logic [7:0] key_byte,
    output logic       key_state,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    ps2_state_e    state, state_n;
    logic          clk_f, data_f, clk_q, fall;
    logic [7:0]    sr;
    logic [2:0]    bit_cnt;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          ext_pend, brk_pend;
    logic          in_frame, timeout, par_ok, load_key;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_flt (
        .clk(clk), .rst(rst), .din(key_clk), .dout(clk_f)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_flt (
        .clk(clk), .rst(rst), .din(key_data), .dout(data_f)
    );

    assign fall     = clk_q & ~clk_f;
    assign in_frame = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
    assign timeout  = in_frame && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHK_EN
    assign par_ok = ^{sr, par};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_n   = state;
        frame_err = 1'b0;
        key_valid = 1'b0;
        load_key  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    if (!data_f) state_n = ST_DATA;
                    else         frame_err = 1'b1;
                end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                if (timeout) begin
                    frame_err = 1'b1;
                    state_n   = ST_IDLE;
                end else if (fall) begin
                    if (state == ST_DATA) begin
                        if (bit_cnt == 3'd7) state_n = ST_PARITY;
                    end else if (state == ST_PARITY) begin
                        state_n = ST_STOP;
                    end else if (data_f && par_ok) begin
                        state_n  = ST_DONE;
                        load_key = !ps2_is_prefix(sr);
                    end else begin
                        frame_err = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                key_valid = !ps2_is_prefix(sr);
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            clk_q     <= 1'b1;
            sr        <= '0;
            bit_cnt   <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_byte  <= '0;
            key_state <= 1'b0;
            key_ext   <= 1'b0;
        end else begin
            state <= state_n;
            clk_q <= clk_f;
            to_cnt <= (fall || !in_frame) ? '0 : to_cnt + 1'b1;

            if (state == ST_IDLE && fall) bit_cnt <= '0;
            if (state == ST_DATA && fall && !timeout) begin
                sr      <= {data_f, sr[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == ST_PARITY && fall && !timeout) par <= data_f;

            // Outputs are loaded on the stop edge so they are already valid in the DONE cycle.
            if (load_key) begin
                key_byte  <= sr;
                key_state <= ~brk_pend;
                key_ext   <= ext_pend;
            end

            if (frame_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (state == ST_DONE) begin
                if (sr == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (sr == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

endmodule
